packed_frame_uart_reader: RTL and testbench

Reads a completed 1-bit-per-pixel packed edge frame out of the frame buffer and streams it to the UART transmitter as a framed byte packet.

- **Where it sits:** on the read port of the frame-buffer BRAM, behind the pixel packer. It is started by the packer's `frame_tick` and feeds the UART TX byte interface toward the plotter host.
- **Packet format:** `SYNC_BYTE`, then `TOTAL_BYTES` payload bytes in address order, then a 1-byte XOR checksum of the payload.

---
 rtl/packed_frame_uart_reader_if.sv | 17 +
 rtl/packed_frame_uart_reader.sv | 131 +++++++++++++
 tb/tb_packed_frame_uart_reader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/packed_frame_uart_reader_if.sv
// packed_frame_uart_reader_if
//   Byte-stream handshake between the frame reader and the UART transmitter.
//   Signals:
//     tx_data  - byte offered to the transmitter
//     tx_valid - tx_data is valid
//     tx_ready - transmitter accepts a byte on tx_valid && tx_ready at a rising edge
//   Modports: master = byte source (reader), slave = byte sink (UART TX).
interface packed_frame_uart_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/packed_frame_uart_reader.sv
// packed_frame_uart_reader
//   Streams a completed 1-bpp packed frame from the frame-buffer BRAM to the
//   UART TX as: SYNC_BYTE, TOTAL_BYTES payload bytes in address order, then
//   an XOR checksum of the payload.
//   Ports:
//     clk, reset  - system clock, synchronous active-high reset
//     frame_tick  - one-cycle pulse: buffer holds a complete frame, start a transfer
//     rAddr/rData - BRAM read port, data valid one cycle after the address
//     tx          - byte stream to UART TX (master side)
//     busy        - transfer in progress
//     done        - one-cycle pulse after the checksum byte is accepted
//     overrun     - sticky: frame_tick seen while not idle
module packed_frame_uart_reader #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    TOTAL_BYTES = 5100,
    parameter int                    ADDR_WIDTH  = $clog2(TOTAL_BYTES),
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    output logic [ADDR_WIDTH-1:0] rAddr,
    input  logic [DATA_WIDTH-1:0] rData,
    packed_frame_uart_reader_if.master tx,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, SEND, CSUM, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TOTAL_BYTES - 1);

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] addr, addr_d, raddr_d;
    logic [DATA_WIDTH-1:0] csum, csum_d, tx_data_d;
    logic                  tx_valid_d, busy_d, done_d, overrun_d;
    logic [DATA_WIDTH-1:0] csum_nxt;

    // Checksum including the byte currently offered in SEND.
    assign csum_nxt = csum ^ tx.tx_data;

    // State and output registers: every output is a flop, loaded from the
    // next-value logic below.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            csum        <= '0;
            rAddr       <= '0;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            addr        <= addr_d;
            csum        <= csum_d;
            rAddr       <= raddr_d;
            tx.tx_data  <= tx_data_d;
            tx.tx_valid <= tx_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            overrun     <= overrun_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (frame_tick) state_d = HDR;
            HDR:     if (tx.tx_ready) state_d = RD_REQ;
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = SEND;
            SEND:    if (tx.tx_ready) state_d = (addr == LAST) ? CSUM : RD_REQ;
            CSUM:    if (tx.tx_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath. Anything not
    // touched holds, which keeps tx_data/tx_valid stable under backpressure.
    always_comb begin
        addr_d     = addr;
        csum_d     = csum;
        raddr_d    = rAddr;
        tx_data_d  = tx.tx_data;
        tx_valid_d = tx.tx_valid;
        busy_d     = busy;
        done_d     = 1'b0;
        overrun_d  = overrun | (frame_tick && state != IDLE);
        case (state)
            IDLE: if (frame_tick) begin
                addr_d     = '0;
                csum_d     = '0;
                busy_d     = 1'b1;
                tx_data_d  = SYNC_BYTE;
                tx_valid_d = 1'b1;
            end
            HDR: if (tx.tx_ready) begin
                tx_valid_d = 1'b0;
                raddr_d    = addr;       // presented during RD_REQ
            end
            RD_WAIT: begin
                tx_data_d  = rData;      // BRAM output for the address of RD_REQ
                tx_valid_d = 1'b1;
            end
            SEND: if (tx.tx_ready) begin
                csum_d = csum_nxt;
                if (addr == LAST) begin
                    tx_data_d = csum_nxt;  // checksum goes out straight from SEND
                end else begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr + 1'b1;
                    raddr_d    = addr + 1'b1;
                end
            end
            CSUM: if (tx.tx_ready) begin
                tx_valid_d = 1'b0;
                done_d     = 1'b1;
            end
            DONE: begin
                busy_d = 1'b0;
                addr_d = '0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_packed_frame_uart_reader.sv
module tb_packed_frame_uart_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        tick_s = 1'b0, tick_b = 1'b0;
    logic [1:0]  raddr_s;
    logic [12:0] raddr_b;
    logic [7:0]  rdata_s, rdata_b;
    logic        busy_s, done_s, ovr_s, busy_b, done_b, ovr_b;

    packed_frame_uart_reader_if #(.DATA_WIDTH(8)) if_s ();
    packed_frame_uart_reader_if #(.DATA_WIDTH(8)) if_b ();

    packed_frame_uart_reader #(.DATA_WIDTH(8), .TOTAL_BYTES(4)) u_s (
        .clk(clk), .reset(reset), .frame_tick(tick_s), .rAddr(raddr_s), .rData(rdata_s),
        .tx(if_s), .busy(busy_s), .done(done_s), .overrun(ovr_s));

    packed_frame_uart_reader #(.DATA_WIDTH(8), .TOTAL_BYTES(5100)) u_b (
        .clk(clk), .reset(reset), .frame_tick(tick_b), .rAddr(raddr_b), .rData(rdata_b),
        .tx(if_b), .busy(busy_b), .done(done_b), .overrun(ovr_b));

    // Small buffer: data is only valid on the cycle after RD_REQ (the cycle
    // after a handshake presents the address); otherwise X.
    logic [7:0] mem_s [4];
    logic       hs_flag_s = 1'b0;
    always @(posedge clk) begin
        rdata_s   <= hs_flag_s ? mem_s[raddr_s] : 8'bx;
        hs_flag_s <= if_s.tx_valid && if_s.tx_ready;
    end

    logic [7:0] mem_b [5100];
    always @(posedge clk) rdata_b <= mem_b[raddr_b];

    // Small-DUT monitor.
    logic [7:0] bytes_q [$];
    logic [1:0] addr_q [$];
    int         hs_cyc_q [$];
    int         cyc = 0, done_cnt = 0, done_cyc = 0, viol = 0, xcnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        cyc++;
        if (if_s.tx_valid && if_s.tx_ready) begin
            bytes_q.push_back(if_s.tx_data);
            addr_q.push_back(raddr_s);
            hs_cyc_q.push_back(cyc);
            if ($isunknown(if_s.tx_data)) xcnt++;
        end
        if (done_s) begin done_cnt++; done_cyc = cyc; end
        if (stall_prev && (!if_s.tx_valid || if_s.tx_data !== stall_data)) viol++;
        stall_prev = if_s.tx_valid && !if_s.tx_ready;
        stall_data = if_s.tx_data;
    end

    // Big-DUT monitor.
    int          nb = 0;
    logic [7:0]  xor_b = 8'h00, first_b = 8'h00, last_b = 8'h00, exp_xor = 8'h00;
    logic [12:0] last_addr_b = '0;
    always @(negedge clk) begin
        if (if_b.tx_valid && if_b.tx_ready) begin
            nb++;
            if (nb == 1) first_b = if_b.tx_data;
            if (nb >= 2 && nb <= 5101) begin
                xor_b       = xor_b ^ if_b.tx_data;
                last_addr_b = raddr_b;
            end
            last_b = if_b.tx_data;
        end
    end

    int         n_cmp = 0, n_fail = 0;
    logic [7:0] exp_s [6];

    task automatic start_s();
        bytes_q.delete(); addr_q.delete(); hs_cyc_q.delete();
        @(posedge clk) #1 tick_s = 1'b1;
        @(posedge clk) #1 tick_s = 1'b0;
    endtask

    // Returns in the DONE cycle (or after the budget expires).
    task automatic wait_done_s(input bit rnd, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_s) begin ok = 1'b1; break; end
            @(posedge clk) #1;
            if_s.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (raddr_s !== 2'd0)      begin n_fail++; $display("FAIL rst_raddr got %0h want 0", raddr_s); end
        n_cmp++; if (if_s.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got %0h want 0", if_s.tx_data); end
        n_cmp++; if (if_s.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b want 0", if_s.tx_valid); end
        n_cmp++; if (busy_s !== 1'b0)        begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_s); end
        n_cmp++; if (done_s !== 1'b0)        begin n_fail++; $display("FAIL rst_done got %b want 0", done_s); end
        n_cmp++; if (ovr_s !== 1'b0)         begin n_fail++; $display("FAIL rst_overrun got %b want 0", ovr_s); end
        n_cmp++; if (busy_b !== 1'b0)        begin n_fail++; $display("FAIL rst_busy_big got %b want 0", busy_b); end
        reset = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic test_basic();
        bit ok;
        if_s.tx_ready = 1'b1;
        start_s();
        n_cmp++; if (if_s.tx_valid !== 1'b1 || if_s.tx_data !== 8'hA5 || busy_s !== 1'b1) begin
            n_fail++; $display("FAIL basic_hdr_timing got v=%b d=%h b=%b want v=1 d=a5 b=1", if_s.tx_valid, if_s.tx_data, busy_s); end
        wait_done_s(1'b0, 100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout got none want done"); end
        @(posedge clk) #1;
        n_cmp++; if (bytes_q.size() !== 6) begin n_fail++; $display("FAIL basic_len got %0d want 6", bytes_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (bytes_q[i] !== exp_s[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, bytes_q[i], exp_s[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (hs_cyc_q[i+1] - hs_cyc_q[i] !== 3) begin n_fail++; $display("FAIL basic_spacing%0d got %0d want 3", i, hs_cyc_q[i+1] - hs_cyc_q[i]); end
            end
            n_cmp++; if (hs_cyc_q[5] - hs_cyc_q[4] !== 1) begin n_fail++; $display("FAIL basic_csum_spacing got %0d want 1", hs_cyc_q[5] - hs_cyc_q[4]); end
            n_cmp++; if (done_cyc !== hs_cyc_q[5] + 1) begin n_fail++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, hs_cyc_q[5] + 1); end
        end
        n_cmp++; if (busy_s !== 1'b0 || done_s !== 1'b0 || if_s.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle got b=%b d=%b v=%b want 0 0 0", busy_s, done_s, if_s.tx_valid); end
        n_cmp++; if (ovr_s !== 1'b0) begin n_fail++; $display("FAIL basic_overrun got %b want 0", ovr_s); end
    endtask

    task automatic test_backpressure();
        bit ok;
        viol = 0; xcnt = 0;
        if_s.tx_ready = 1'b0;
        start_s();
        wait_done_s(1'b1, 400, ok);
        if_s.tx_ready = 1'b1;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout got none want done"); end
        @(posedge clk) #1;
        n_cmp++; if (bytes_q.size() !== 6) begin n_fail++; $display("FAIL bp_len got %0d want 6", bytes_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (bytes_q[i] !== exp_s[i]) begin n_fail++; $display("FAIL bp_byte%0d got %h want %h", i, bytes_q[i], exp_s[i]); end
            end
            for (int i = 1; i < 5; i++) begin
                n_cmp++; if (addr_q[i] !== 2'(i - 1)) begin n_fail++; $display("FAIL bp_raddr%0d got %0d want %0d", i - 1, addr_q[i], i - 1); end
            end
        end
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d violations want 0", viol); end
        n_cmp++; if (xcnt !== 0) begin n_fail++; $display("FAIL bp_no_x got %0d unknown bytes want 0", xcnt); end
    endtask

    task automatic test_overrun();
        bit ok;
        start_s();
        repeat (6) @(posedge clk) #1;
        tick_s = 1'b1;
        @(posedge clk) #1 tick_s = 1'b0;
        wait_done_s(1'b0, 100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovr_done_timeout got none want done"); end
        @(posedge clk) #1;
        n_cmp++; if (ovr_s !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", ovr_s); end
        n_cmp++; if (bytes_q.size() !== 6) begin n_fail++; $display("FAIL ovr_len got %0d want 6", bytes_q.size()); end
        else for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bytes_q[i] !== exp_s[i]) begin n_fail++; $display("FAIL ovr_byte%0d got %h want %h", i, bytes_q[i], exp_s[i]); end
        end
        start_s();
        wait_done_s(1'b0, 100, ok);
        @(posedge clk) #1;
        n_cmp++; if (!ok || bytes_q.size() !== 6 || bytes_q[5] !== 8'h87) begin
            n_fail++; $display("FAIL ovr_fresh_packet got ok=%b len=%0d want ok=1 len=6 csum=87", ok, bytes_q.size()); end
        n_cmp++; if (ovr_s !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", ovr_s); end
    endtask

    task automatic test_done_tick();
        bit ok;
        reset = 1'b1; @(posedge clk) #1 reset = 1'b0;
        start_s();
        wait_done_s(1'b0, 100, ok);
        tick_s = 1'b1;                      // lands in the DONE cycle
        @(posedge clk) #1 tick_s = 1'b0;
        n_cmp++; if (ovr_s !== 1'b1) begin n_fail++; $display("FAIL done_tick_overrun got %b want 1", ovr_s); end
        n_cmp++; if (busy_s !== 1'b0 || if_s.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL done_tick_ignored got b=%b v=%b want 0 0", busy_s, if_s.tx_valid); end
        reset = 1'b1; @(posedge clk) #1 reset = 1'b0;
        start_s();
        wait_done_s(1'b0, 100, ok);
        @(posedge clk) #1 tick_s = 1'b1;    // first IDLE cycle after DONE
        @(posedge clk) #1 tick_s = 1'b0;
        n_cmp++; if (if_s.tx_valid !== 1'b1 || if_s.tx_data !== 8'hA5 || busy_s !== 1'b1) begin
            n_fail++; $display("FAIL idle_tick_accept got v=%b d=%h b=%b want 1 a5 1", if_s.tx_valid, if_s.tx_data, busy_s); end
        n_cmp++; if (ovr_s !== 1'b0) begin n_fail++; $display("FAIL idle_tick_overrun got %b want 0", ovr_s); end
        wait_done_s(1'b0, 100, ok);
        @(posedge clk) #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int dc, i;
        start_s();
        for (i = 0; i < 50; i++) begin
            if (bytes_q.size() == 3 && if_s.tx_valid) break;
            @(posedge clk) #1;
        end
        n_cmp++; if (i == 50) begin n_fail++; $display("FAIL mid_reach_send got timeout want byte2 in SEND"); end
        n_cmp++; if (if_s.tx_data !== 8'h04) begin n_fail++; $display("FAIL mid_byte2 got %h want 04", if_s.tx_data); end
        dc = done_cnt;
        reset = 1'b1;
        @(posedge clk) #1 reset = 1'b0;
        n_cmp++; if ({raddr_s, if_s.tx_data, if_s.tx_valid, busy_s, done_s, ovr_s} !== 14'd0) begin
            n_fail++; $display("FAIL mid_outputs got a=%0d d=%h v=%b b=%b dn=%b o=%b want all 0",
                               raddr_s, if_s.tx_data, if_s.tx_valid, busy_s, done_s, ovr_s); end
        repeat (10) @(posedge clk) #1;
        n_cmp++; if (done_cnt !== dc) begin n_fail++; $display("FAIL mid_no_done got %0d want %0d", done_cnt, dc); end
        start_s();
        wait_done_s(1'b0, 100, ok);
        @(posedge clk) #1;
        n_cmp++; if (bytes_q.size() !== 6) begin n_fail++; $display("FAIL mid_len got %0d want 6", bytes_q.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++; if (bytes_q[k] !== exp_s[k]) begin n_fail++; $display("FAIL mid_byte%0d got %h want %h", k, bytes_q[k], exp_s[k]); end
            end
            n_cmp++; if (addr_q[1] !== 2'd0) begin n_fail++; $display("FAIL mid_raddr0 got %0d want 0", addr_q[1]); end
        end
    endtask

    task automatic test_full_size();
        int i;
        @(posedge clk) #1 tick_b = 1'b1;
        @(posedge clk) #1 tick_b = 1'b0;
        for (i = 0; i < 20000; i++) begin
            if (done_b) break;
            @(posedge clk) #1;
        end
        n_cmp++; if (i == 20000) begin n_fail++; $display("FAIL full_done_timeout got none want done"); end
        @(posedge clk) #1;
        n_cmp++; if (nb !== 5102) begin n_fail++; $display("FAIL full_len got %0d want 5102", nb); end
        n_cmp++; if (first_b !== 8'hA5) begin n_fail++; $display("FAIL full_hdr got %h want a5", first_b); end
        n_cmp++; if (xor_b !== exp_xor) begin n_fail++; $display("FAIL full_payload_xor got %h want %h", xor_b, exp_xor); end
        n_cmp++; if (last_b !== exp_xor) begin n_fail++; $display("FAIL full_csum got %h want %h", last_b, exp_xor); end
        n_cmp++; if (last_addr_b !== 13'd5099) begin n_fail++; $display("FAIL full_last_raddr got %0d want 5099", last_addr_b); end
        n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL full_idle got %b want 0", busy_b); end
    endtask

    initial begin
        mem_s[0] = 8'h01; mem_s[1] = 8'h02; mem_s[2] = 8'h04; mem_s[3] = 8'h80;
        exp_s[0] = 8'hA5; exp_s[1] = 8'h01; exp_s[2] = 8'h02;
        exp_s[3] = 8'h04; exp_s[4] = 8'h80; exp_s[5] = 8'h87;
        for (int k = 0; k < 5100; k++) begin
            mem_b[k] = 8'($urandom);
            exp_xor  = exp_xor ^ mem_b[k];
        end
        if_s.tx_ready = 1'b1;
        if_b.tx_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_done_tick();
        test_reset_mid();
        test_full_size();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
